fft_butterfly_cfg: RTL and testbench

Parametrised radix-2 FFT butterfly, successor to the fixed-format butterfly in the FFT pipeline stages. It supports run-time DIF/DIT mode, configurable data and twiddle widths, and optional per-pair divide-by-2 scaling with saturation. It generates its own twiddles from an internal index counter with explicit frame resync, and provides ready/valid backpressure. It sits between the stage delay-commutator and the next stage, and both outputs emerge aligned at a fixed latency.

---
 rtl/fft_butterfly_cfg_if.sv | 16 +
 rtl/fft_butterfly_cfg.sv | 113 +++++++++++
 tb/tb_fft_butterfly_cfg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_cfg_if.sv
// fft_butterfly_cfg_if: pair-in/pair-out streaming bundle with ready/valid on both sides.
interface fft_butterfly_cfg_if #(
    parameter int DATA_W = 16
);
    logic in_valid, in_ready, mode, scale, sync_clr, out_valid, out_ready;
    logic signed [DATA_W-1:0] up_re, up_im, dn_re, dn_im;
    logic signed [DATA_W-1:0] out0_re, out0_im, out1_re, out1_im;
    modport master (
        output in_valid, up_re, up_im, dn_re, dn_im, mode, scale, sync_clr, out_ready,
        input  in_ready, out_valid, out0_re, out0_im, out1_re, out1_im
    );
    modport slave (
        input  in_valid, up_re, up_im, dn_re, dn_im, mode, scale, sync_clr, out_ready,
        output in_ready, out_valid, out0_re, out0_im, out1_re, out1_im
    );
endinterface

// File: rtl/fft_butterfly_cfg.sv
// fft_butterfly_cfg: 6-stage radix-2 DIF/DIT butterfly with internal twiddle index, optional >>1 and saturation.
module fft_butterfly_cfg #(
    parameter int DATA_W = 16,
    parameter int TW_W = 16,
    parameter int SET = 4
) (
    input logic clk,
    input logic rst_n,
    fft_butterfly_cfg_if.slave bus
);
    localparam int HALF = 2 ** (SET - 1);
    localparam int KW = SET > 1 ? SET - 1 : 1;
    localparam int AW = DATA_W + 1;
    localparam int PW = AW + TW_W;
    localparam int MW = DATA_W + 3;
    localparam int OW = DATA_W + 4;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);
    localparam logic signed [OW-1:0] MAXV = {{(OW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [OW-1:0] MINV = ~MAXV;

    function automatic logic signed [TW_W-1:0] tw(input int i, input logic im);
        real ang, amp, v;
        ang = 2.0 * 3.141592653589793 * i / (2.0 ** SET);
        amp = (2.0 ** (TW_W - 1)) - 1.0;
        v = im ? -$sin(ang) * amp : $cos(ang) * amp;
        return TW_W'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [OW-1:0] x, input logic sc);
        logic signed [OW-1:0] y;
        y = sc ? x >>> 1 : x;
        return y > MAXV ? MAXV[DATA_W-1:0] : y < MINV ? MINV[DATA_W-1:0] : y[DATA_W-1:0];
    endfunction

    logic signed [TW_W-1:0] rom_re [HALF];
    logic signed [TW_W-1:0] rom_im [HALF];
    for (genvar i = 0; i < HALF; i++) begin : g_rom
        assign rom_re[i] = tw(i, 1'b0);
        assign rom_im[i] = tw(i, 1'b1);
    end

    logic en, acc;
    logic [KW-1:0] k, k_use, k1;
    logic [5:0] vld;
    logic [3:0] md;
    logic [4:0] sc;
    logic signed [DATA_W-1:0] u1_re, u1_im, d1_re, d1_im;
    logic signed [AW-1:0] c2_re, c2_im, a_re, a_im, c3_re, c3_im, c4_re, c4_im;
    logic signed [TW_W-1:0] w_re, w_im;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [MW-1:0] m_re, m_im;
    logic signed [OW-1:0] o0_re, o0_im, o1_re, o1_im;

    assign en = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = en;
    assign bus.out_valid = vld[5];
    assign acc = bus.in_valid && en;
    assign k_use = bus.sync_clr ? '0 : k;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k <= '0;
            vld <= '0;
            bus.out0_re <= '0;
            bus.out0_im <= '0;
            bus.out1_re <= '0;
            bus.out1_im <= '0;
        end else begin
            if (acc) k <= (k_use == KW'(HALF - 1)) ? '0 : k_use + KW'(1);
            else if (bus.sync_clr) k <= '0;
            if (en) begin
                vld <= {vld[4:0], acc};
                bus.out0_re <= sat(o0_re, sc[4]);
                bus.out0_im <= sat(o0_im, sc[4]);
                bus.out1_re <= sat(o1_re, sc[4]);
                bus.out1_im <= sat(o1_im, sc[4]);
            end
        end
    end

    // c carries the DIF sum or the DIT upper input; a is the multiplicand
    always_ff @(posedge clk) begin
        if (en) begin
            u1_re <= bus.up_re;
            u1_im <= bus.up_im;
            d1_re <= bus.dn_re;
            d1_im <= bus.dn_im;
            k1 <= k_use;
            md <= {md[2:0], bus.mode};
            sc <= {sc[3:0], bus.scale};
            w_re <= rom_re[k1];
            w_im <= rom_im[k1];
            c2_re <= md[0] ? AW'(u1_re) : AW'(u1_re) + AW'(d1_re);
            c2_im <= md[0] ? AW'(u1_im) : AW'(u1_im) + AW'(d1_im);
            a_re <= md[0] ? AW'(d1_re) : AW'(u1_re) - AW'(d1_re);
            a_im <= md[0] ? AW'(d1_im) : AW'(u1_im) - AW'(d1_im);
            p_rr <= PW'(a_re) * PW'(w_re);
            p_ii <= PW'(a_im) * PW'(w_im);
            p_ri <= PW'(a_re) * PW'(w_im);
            p_ir <= PW'(a_im) * PW'(w_re);
            c3_re <= c2_re;
            c3_im <= c2_im;
            m_re <= MW'((p_rr - p_ii + RND) >>> (TW_W - 1));
            m_im <= MW'((p_ri + p_ir + RND) >>> (TW_W - 1));
            c4_re <= c3_re;
            c4_im <= c3_im;
            o0_re <= md[3] ? OW'(c4_re) + OW'(m_re) : OW'(c4_re);
            o0_im <= md[3] ? OW'(c4_im) + OW'(m_im) : OW'(c4_im);
            o1_re <= md[3] ? OW'(c4_re) - OW'(m_re) : OW'(m_re);
            o1_im <= md[3] ? OW'(c4_im) - OW'(m_im) : OW'(m_im);
        end
    end
endmodule

// File: tb/tb_fft_butterfly_cfg.sv
// tb_fft_butterfly_cfg: table-driven directed vectors plus latency, stall and reset sequences (N=8).
module tb_fft_butterfly_cfg;
    typedef struct {
        logic signed [15:0] ur, ui, dr, di;
        logic md, sc, sy;
        logic signed [15:0] o0r, o0i, o1r, o1i;
    } vec_t;

    logic clk = 0;
    logic rst_n = 0;
    int checks = 0, errors = 0, n_out = 0;
    logic [63:0] q[$];
    logic stalled = 0;
    logic [63:0] held = '0;
    logic [63:0] outs;
    vec_t tbl[15];

    always #5 clk = ~clk;

    fft_butterfly_cfg_if #(.DATA_W(16)) bus ();
    fft_butterfly_cfg #(.DATA_W(16), .TW_W(16), .SET(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign outs = {bus.out0_re, bus.out0_im, bus.out1_re, bus.out1_im};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int ur, ui, dr, di, md, sc, sy, o0r, o0i, o1r, o1i);
        vec_t v;
        v.ur = 16'(ur); v.ui = 16'(ui); v.dr = 16'(dr); v.di = 16'(di);
        v.md = md[0]; v.sc = sc[0]; v.sy = sy[0];
        v.o0r = 16'(o0r); v.o0i = 16'(o0i); v.o1r = 16'(o1r); v.o1i = 16'(o1i);
        return v;
    endfunction

    task automatic send(input vec_t v);
        int n = 0;
        bus.up_re = v.ur; bus.up_im = v.ui; bus.dn_re = v.dr; bus.dn_im = v.di;
        bus.mode = v.md; bus.scale = v.sc; bus.sync_clr = v.sy; bus.in_valid = 1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 64'(bus.in_ready), 64'd1);
        q.push_back({v.o0r, v.o0i, v.o1r, v.o1i});
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.sync_clr = 0;
    endtask

    task automatic latency(input string name);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n + 1), 64'd6);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) stalled = 0;
        else begin
            if (stalled) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", outs, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                else chk("out_data", outs, q.pop_front());
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = outs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0, seen;
        bus.in_valid = 0; bus.out_ready = 1; bus.mode = 0; bus.scale = 0; bus.sync_clr = 0;
        bus.up_re = 0; bus.up_im = 0; bus.dn_re = 0; bus.dn_im = 0;
        //           up re/im     dn re/im      md sc sy  out0 re/im     out1 re/im
        tbl[0]  = mk(1000, 200,   400, -100,    0, 0, 1,  1400, 100,     600, 300);
        tbl[1]  = mk(1000, 0,     0, 0,         0, 0, 0,  1000, 0,       707, -707);
        tbl[2]  = mk(0, 0,        1000, 0,      1, 0, 0,  0, -1000,      0, 1000);
        tbl[3]  = mk(1000, 0,     0, 0,         0, 0, 0,  1000, 0,       -707, -707);
        tbl[4]  = mk(32767, 0,    32767, 0,     0, 0, 0,  32767, 0,      0, 0);
        tbl[5]  = mk(32767, 0,    32767, 0,     0, 1, 0,  32767, 0,      0, 0);
        tbl[6]  = mk(-32768, 0,   -32768, 0,    0, 0, 0,  -32768, 0,     0, 0);
        tbl[7]  = mk(2000, 0,     1000, 0,      1, 1, 0,  646, -354,     1353, 353);
        tbl[8]  = mk(1000, 0,     0, 0,         0, 0, 1,  1000, 0,       1000, 0);
        tbl[9]  = mk(1000, 0,     0, 0,         0, 0, 0,  1000, 0,       707, -707);
        tbl[10] = mk(1000, 0,     0, 0,         0, 0, 1,  1000, 0,       1000, 0);
        tbl[11] = mk(1000, 0,     0, 0,         0, 0, 0,  1000, 0,       707, -707);
        tbl[12] = mk(1000, 0,     0, 0,         0, 0, 0,  1000, 0,       0, -1000);
        tbl[13] = mk(32767, -32768, 32767, 32767, 1, 0, 1, 32767, -2,    1, -32768);
        tbl[14] = mk(-3, 0,       0, 0,         0, 1, 0,  -2, 0,         -1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", outs, 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1;

        send(tbl[0]);
        latency("latency_first");
        drain("drain_first");

        for (int i = 0; i < 15; i++) send(tbl[i]);
        drain("drain_table");

        n0 = n_out;
        fork
            for (int i = 0; i < 10; i++)
                send(mk(100 * i + 1, -i, 0, 0, 1, 0, 0, 100 * i + 1, -i, 100 * i + 1, -i));
            begin
                repeat (8) @(posedge clk);
                #1;
                bus.out_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1;
            end
        join
        drain("drain_stall");
        chk("stall_count", 64'(n_out - n0), 64'd10);

        send(tbl[1]);
        send(tbl[8]);
        send(tbl[9]);
        send(tbl[12]);
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        q.delete();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data", outs, 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_flush", 64'(seen), 64'd0);
        send(mk(1000, 0, 0, 0, 0, 0, 0, 1000, 0, 1000, 0));
        latency("latency_after_rst");
        drain("drain_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
